// File: rtl/mem_refill_ctrl_pkg.sv
// Shared types and defaults for the cache-side refill/write-through memory master.
package mem_refill_ctrl_pkg;
  localparam int ADDR_WIDTH_D     = 10;
  localparam int DATA_WIDTH_D     = 32;
  localparam int WORDS_PER_LINE_D = 4;
  localparam int SLOT_W           = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    LAST  = 3'd2,
    FDONE = 3'd3,
    WRITE = 3'd4
  } state_e;
endpackage

// File: rtl/mem_refill_ctrl_line_capture_buf.sv
// Line register filled one word per beat; a write to slot 0 clears the other slots
// so a new line never mixes with the previous one.
module mem_refill_ctrl_line_capture_buf
  import mem_refill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_D
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 we,
  input  logic [SLOT_W-1:0]                    idx,
  input  logic [DATA_WIDTH-1:0]                d,
  input  logic                                 clr,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line
);
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] slot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (we && idx == SLOT_W'(k)) slot_q[k] <= d;
        else if (clr)                slot_q[k] <= '0;
      end
    end
  end

  assign line = slot_q;
endmodule

// File: rtl/mem_refill_ctrl.sv
// Cache-side memory master: 4-beat burst line refill or single-word write-through,
// one request at a time.
module mem_refill_ctrl
  import mem_refill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_D,
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_D  // must stay 4: memory burst counter is 2 bits
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  input  logic                                 req_write,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]                req_wdata,
  output logic                                 req_ready,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_data,
  output logic                                 fill_done,
  output logic                                 wr_done,
  output logic [ADDR_WIDTH-1:0]                mem_word_address,
  output logic [DATA_WIDTH-1:0]                mem_data_in,
  output logic                                 mem_write,
  output logic                                 mem_move,
  input  logic [DATA_WIDTH-1:0]                mem_data
);
  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    cap_vld;
  logic [SLOT_W-1:0]       cap_idx;
  logic                    accept;

  assign accept = (state_q == IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    mem_move    = 1'b0;
    mem_write   = 1'b0;
    fill_done   = 1'b0;
    wr_done     = 1'b0;
    mem_data_in = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_write ? WRITE : FILL;
      end
      FILL: begin
        mem_move = 1'b1;
        if (cnt_q == SLOT_W'(WORDS_PER_LINE - 1)) state_d = LAST;
      end
      // mem_move low here clears the memory's beat counter for the next burst
      LAST:  state_d = FDONE;
      FDONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      WRITE: begin
        mem_write   = 1'b1;
        wr_done     = 1'b1;
        mem_data_in = wdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory data lags the beat that requested it by one edge, so capture
  // uses the beat index registered on the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= '0;
        addr_q <= req_write ? req_addr : {req_addr[ADDR_WIDTH-1:SLOT_W], {SLOT_W{1'b0}}};
        if (req_write) wdata_q <= req_wdata;
      end else if (state_q == FILL) begin
        cnt_q <= cnt_q + SLOT_W'(1);
      end
      cap_vld <= (state_q == FILL);
      cap_idx <= cnt_q;
    end
  end

  assign mem_word_address = addr_q;

  mem_refill_ctrl_line_capture_buf #(
    .DATA_WIDTH     (DATA_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (cap_vld),
    .idx  (cap_idx),
    .d    (mem_data),
    .clr  (cap_vld && cap_idx == '0),
    .line (line_data)
  );
endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl with a behavioural burst memory.
module tb_mem_refill_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_write;
  logic [9:0]   req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready, fill_done, wr_done, mem_write, mem_move;
  logic [127:0] line_data;
  logic [9:0]   mem_word_address;
  logic [31:0]  mem_data_in;
  logic [31:0]  mem_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .line_data(line_data), .fill_done(fill_done), .wr_done(wr_done),
    .mem_word_address(mem_word_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_move(mem_move), .mem_data(mem_data)
  );

  // Memory: preset contents plus a write-overlay
  logic [31:0] wmem [0:1023];
  bit          wv   [0:1023];
  logic [1:0]  mcnt = '0;

  function automatic logic [31:0] init_val(input logic [9:0] a);
    case (a)
      10'h040: return 32'hA0;  10'h041: return 32'hA1;
      10'h042: return 32'hA2;  10'h043: return 32'hA3;
      10'h000: return 32'h10;  10'h001: return 32'h11;
      10'h002: return 32'h12;  10'h003: return 32'h13;
      10'h120: return 32'hC0;  10'h121: return 32'hC1;
      10'h122: return 32'hC2;  10'h123: return 32'hC3;
      10'h3FC: return 32'hF0;  10'h3FD: return 32'hF1;
      10'h3FE: return 32'hF2;  10'h3FF: return 32'hF3;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [9:0] a);
    return wv[a] ? wmem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_move) begin
      mem_data <= rd({mem_word_address[9:2], mcnt});
      mcnt     <= mcnt + 2'd1;
    end else begin
      mcnt <= 2'd0;
      if (mem_write) begin
        wmem[mem_word_address] <= mem_data_in;
        wv[mem_word_address]   <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues a refill at the current negedge; returns at the negedge of the fill_done cycle.
  task automatic refill(input logic [9:0] a, input logic [127:0] exp_line, input string tag,
                        input bit hold_wr);
    int cyc, moves, bad_addr, wr_seen;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    if (hold_wr) begin
      req_write = 1'b1; req_addr = 10'h200; req_wdata = 32'h5555AAAA;
    end else begin
      req_valid = 1'b0; req_addr = 10'h2AA;
    end
    cyc = 1; moves = 0; bad_addr = 0; wr_seen = 0;
    while (!fill_done && cyc < 20) begin
      if (mem_move) begin
        moves++;
        if (mem_word_address != {a[9:2], 2'b00}) bad_addr++;
      end
      if (mem_write) wr_seen++;
      @(negedge clk); cyc++;
    end
    chk({tag, ".latency"}, cyc, 6);
    chk({tag, ".move_cycles"}, moves, 4);
    chk({tag, ".bad_addr"}, bad_addr, 0);
    chk({tag, ".no_write"}, wr_seen, 0);
    chk({tag, ".line"}, line_data, exp_line);
    chk({tag, ".move_low_fdone"}, mem_move, 0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    chk("wr.mem_write", mem_write, 1);
    chk("wr.addr", mem_word_address, a);
    chk("wr.data", mem_data_in, d);
    chk("wr.done", wr_done, 1);
    chk("wr.ready_low", req_ready, 0);
    @(negedge clk);
    chk("wr.write_drop", mem_write, 0);
    chk("wr.data_zero", mem_data_in, 0);
    chk("wr.ready_back", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", req_ready, 1);
    chk("rst.move", mem_move, 0);
    chk("rst.write", mem_write, 0);
    chk("rst.fill_done", fill_done, 0);
    chk("rst.wr_done", wr_done, 0);
    chk("rst.line", line_data, 0);
    chk("rst.addr", mem_word_address, 0);
    chk("rst.data_in", mem_data_in, 0);
    rst = 1'b1;
    @(negedge clk);

    refill(10'h041, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "fill040", 0);
    @(negedge clk);
    chk("fill040.hold_addr", mem_word_address, 10'h040);

    wr(10'h123, 32'hDEADBEEF);
    refill(10'h120, {32'hDEADBEEF, 32'hC2, 32'hC1, 32'hC0}, "fill120", 0);
    @(negedge clk);

    // back-to-back bursts
    refill(10'h000, {32'h13, 32'h12, 32'h11, 32'h10}, "b2b0", 0);
    @(negedge clk);
    chk("b2b.ready", req_ready, 1);
    chk("b2b.gap_move", mem_move, 0);
    refill(10'h3FC, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, "b2b1", 0);
    @(negedge clk);

    // reset during the 3rd FILL cycle
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h040;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.in_fill", mem_move, 1);
    rst = 1'b0;
    #1;
    chk("mid.move", mem_move, 0);
    chk("mid.ready", req_ready, 1);
    chk("mid.line", line_data, 0);
    chk("mid.addr", mem_word_address, 0);
    @(negedge clk);
    rst = 1'b1;
    refill(10'h042, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "after_rst", 0);
    @(negedge clk);

    // write held during a refill waits for req_ready
    refill(10'h000, {32'h13, 32'h12, 32'h11, 32'h10}, "held", 1);
    @(negedge clk);
    chk("held.ready", req_ready, 1);
    chk("held.no_write_yet", mem_write, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held.write", mem_write, 1);
    chk("held.addr", mem_word_address, 10'h200);
    chk("held.data", mem_data_in, 32'h5555AAAA);
    @(negedge clk);

    refill(10'h3FF, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, "top", 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_refill_ctrl.md
Name: mem_refill_ctrl

Overview:
- Cache-side master for the main data memory port.
- Accepts one request at a time from the cache: a line refill or a single-word write-through.
- For a refill, drives the memory's 4-beat burst read and collects the four returned words into a line buffer; for a write, drives one memory write cycle.
- Sits between the cache controller and main memory; its outputs connect directly to the memory's address, data-in, write and burst-read inputs.

Parameters:
- ADDR_WIDTH, 10, word address width; must match the memory's word address.
- DATA_WIDTH, 32, word width.
- WORDS_PER_LINE, 4, words per line. Fixed to 4 because the memory's burst counter is 2 bits; any other value is illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_write  in  1  1 = write-through, 0 = line refill.
- req_addr  in  ADDR_WIDTH  word address; for a refill, bits [1:0] are ignored.
- req_wdata  in  DATA_WIDTH  write data.
- req_ready  out  1  high in IDLE only; a request is accepted on a clock edge where req_valid and req_ready are both 1.
- line_data  out  WORDS_PER_LINE*DATA_WIDTH  refilled line; word k is at bits [32k+31:32k].
- fill_done  out  1  one-cycle pulse; line_data is complete.
- wr_done  out  1  one-cycle pulse; the write has been issued to memory.
- mem_word_address  out  ADDR_WIDTH  to memory Word_address.
- mem_data_in  out  DATA_WIDTH  to memory Data_In.
- mem_write  out  1  to memory write_in_mem.
- mem_move  out  1  to memory move_to_cache.
- mem_data  in  DATA_WIDTH  from memory data, registered in memory.

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready = 1; line buffer, beat counter and captured address cleared.
- Memory contract:
  - Each edge with mem_move = 1 returns mem[{addr[9:2], cnt}] on mem_data after that edge, then increments the memory's counter.
  - Any edge with mem_move = 0 and mem_write = 0 resets the memory's counter.
  - mem_move and mem_write are never both 1.
- States: IDLE, FILL, LAST, FDONE, WRITE.
- IDLE:
  - On accept with req_write = 0: latch {req_addr[9:2], 2'b00}, beat counter = 0, go to FILL.
  - On accept with req_write = 1: latch address and data, go to WRITE.
  - Otherwise: mem_move = 0, mem_write = 0.
- FILL:
  - mem_move = 1; mem_word_address = latched line address, stable for the whole burst.
  - Beat counter counts 0..3; on counter = 3, go to LAST.
  - Capture pipeline: at each edge in FILL with counter ≥ 1, and at the edge leaving LAST, store mem_data into line slot (counter − 1), or slot 3 at LAST.
  - Implement as a 1-cycle delayed capture-valid/index register.
- LAST:
  - mem_move = 0, which clears the memory counter so back-to-back bursts start at word 0.
  - Capture word 3; go to FDONE.
- FDONE: fill_done = 1 for one cycle; line_data is valid from this cycle until the next refill starts writing slots; go to IDLE.
- Refill latency: accept edge, then 4 FILL cycles + LAST + FDONE; fill_done is high in the 6th cycle after the accept edge.
- WRITE:
  - mem_write = 1, mem_word_address = latched address, mem_data_in = latched data, for exactly one cycle.
  - wr_done = 1 in the same cycle; go to IDLE.
- mem_data_in is 0 outside WRITE; mem_word_address holds its last value in IDLE.
- Back-to-back requests: req_ready returns high the cycle after FDONE/WRITE; a request accepted then starts a fresh burst with the memory counter already 0.
- req_addr changes after accept have no effect; inputs are latched.
- Reset mid-burst: immediate return to IDLE with outputs at reset values; mem_move drops, so the memory counter is cleared; partial line contents are discarded (zeroed).
- req_valid held high in non-IDLE states is ignored; there is no queuing.

Decomposition:
- Shared package:
  - state encoding (IDLE = 0, FILL = 1, LAST = 2, FDONE = 3, WRITE = 4);
  - ADDR_WIDTH, DATA_WIDTH and WORDS_PER_LINE defaults;
  - a line-slot index width constant of 2.
- One natural sub-module, line_capture_buf: the 4×DATA_WIDTH line register with write-enable + 2-bit index and synchronous clear.
- FSM and memory drive stay in the top module.

Test Plan:
- Preload memory words 0x40..0x43 with 0xA0..0xA3; refill req_addr = 0x041 → mem_move high exactly 4 cycles with address 0x040; fill_done in cycle 6; line_data = {0xA3, 0xA2, 0xA1, 0xA0}.
- Write req_addr = 0x123, data 0xDEADBEEF → mem_write for 1 cycle with matching address/data, wr_done pulse; a subsequent refill of 0x120 returns 0xDEADBEEF in slot 3.
- Two back-to-back refills (0x000 then 0x3FC, distinct data) → mem_move low for at least one cycle between bursts; second line ordered words 0..3, with no counter carry-over.
- Assert rst during the 3rd FILL cycle → all outputs at reset values asynchronously, req_ready = 1; the next refill of the same line returns the correct full line.
- req_valid held high with a write request during a refill → no mem_write until after fill_done; the write is accepted the cycle req_ready rises.
- Refill at the top line 0x3FF → address 0x3FC used; slots map to 0x3FC..0x3FF with no wrap beyond.
